// File: rtl/ppi_pkg.sv
// Purpose: shared constants and types for the PPI handshake controller (mode encodings, control-word and INTE bit positions).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ppi_pkg;

  // Group A mode field, control word bits [6:5]
  typedef enum logic [1:0] {
    AM_BASIC   = 2'b00,  // mode 0
    AM_STROBED = 2'b01,  // mode 1
    AM_BIDIR   = 2'b10,  // not supported -> cfg_err
    AM_RSVD    = 2'b11   // not supported -> cfg_err
  } amode_e;

  // Control word bit indices (mode-set form, din[7]=1)
  localparam int CW_SET      = 7;
  localparam int CW_AMODE_HI = 6;
  localparam int CW_AMODE_LO = 5;
  localparam int CW_DIR_A    = 4;
  localparam int CW_DIR_CU   = 3;
  localparam int CW_MODE_B   = 2;
  localparam int CW_DIR_B    = 1;
  localparam int CW_DIR_CL   = 0;

  // Bit set/reset form (din[7]=0): din[3:1] selects the port C bit, din[0] is the value
  localparam int BSR_SEL_HI  = 3;
  localparam int BSR_SEL_LO  = 1;
  localparam int BSR_VAL     = 0;

  // Port C bits that double as interrupt enables
  localparam logic [2:0] INTE_A_IN_BIT  = 3'd4;
  localparam logic [2:0] INTE_A_OUT_BIT = 3'd6;
  localparam logic [2:0] INTE_B_BIT     = 3'd2;

  typedef struct packed {
    logic mode_a;
    logic mode_b;
    logic dir_a;
    logic dir_cu;
    logic dir_b;
    logic dir_cl;
  } cfg_t;

  // All ports basic mode, all directions input
  localparam cfg_t CFG_RST = '{mode_a: 1'b0, mode_b: 1'b0, dir_a: 1'b1,
                               dir_cu: 1'b1, dir_b: 1'b1, dir_cl: 1'b1};

  function automatic logic amode_is_legal(input amode_e m);
    return (m == AM_BASIC) || (m == AM_STROBED);
  endfunction

endpackage

// File: rtl/ppi_hs_ctrl_if.sv
// Purpose: CPU and peripheral-side signal bundle of the PPI handshake controller.
// Latency: n/a (wires only).
// Backpressure: none; strobes are single-cycle, handshake inputs are asynchronous active-low.
// Ports: CPU wr_ctrl/din/rd_*/wr_*, peripheral stb_*_n/ack_*_n; config mode_*/dir_*/cfg_err,
//        port C latch pc_out, status ibf_*/obf_*_n/intr_*.
// master = the CPU/peripheral side driving strobes; slave = the controller.
interface ppi_hs_ctrl_if;
  logic       wr_ctrl;
  logic [7:0] din;
  logic       rd_a;
  logic       wr_a;
  logic       rd_b;
  logic       wr_b;
  logic       stb_a_n;
  logic       ack_a_n;
  logic       stb_b_n;
  logic       ack_b_n;
  logic       mode_a;
  logic       mode_b;
  logic       dir_a;
  logic       dir_cu;
  logic       dir_b;
  logic       dir_cl;
  logic [7:0] pc_out;
  logic       cfg_err;
  logic       ibf_a;
  logic       ibf_b;
  logic       obf_a_n;
  logic       obf_b_n;
  logic       intr_a;
  logic       intr_b;

  modport master (
    output wr_ctrl, din, rd_a, wr_a, rd_b, wr_b, stb_a_n, ack_a_n, stb_b_n, ack_b_n,
    input  mode_a, mode_b, dir_a, dir_cu, dir_b, dir_cl, pc_out, cfg_err,
           ibf_a, ibf_b, obf_a_n, obf_b_n, intr_a, intr_b
  );

  modport slave (
    input  wr_ctrl, din, rd_a, wr_a, rd_b, wr_b, stb_a_n, ack_a_n, stb_b_n, ack_b_n,
    output mode_a, mode_b, dir_a, dir_cu, dir_b, dir_cl, pc_out, cfg_err,
           ibf_a, ibf_b, obf_a_n, obf_b_n, intr_a, intr_b
  );
endinterface

// File: rtl/ppi_hs_chan.sv
// Purpose: one handshake port: synchronisers + edge detect on stb_n/ack_n, ibf/obf_n/intr flags.
// Latency: flag set SYNC_STAGES+1 edges after the pin changes; rd/wr clear at the next edge.
// Backpressure: none; strobes are single-cycle and always accepted.
// Ports: clk, reset (async high); mode/dir/inte config; clr (mode set); rd/wr strobes;
//        stb_n/ack_n async pins; ibf/obf_n/intr registered status.
module ppi_hs_chan #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic mode,
  input  logic dir,
  input  logic inte,
  input  logic clr,
  input  logic rd,
  input  logic wr,
  input  logic stb_n,
  input  logic ack_n,
  output logic ibf,
  output logic obf_n,
  output logic intr
);

  logic [SYNC_STAGES-1:0] stb_sync_q, stb_sync_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic stb_hist_q, stb_hist_d;
  logic ack_hist_q, ack_hist_d;
  logic ibf_q, ibf_d;
  logic obf_n_q, obf_n_d;
  logic intr_q, intr_d;
  logic stb_fall, stb_rise, ack_fall, ack_rise;

  // Synchronisers always run, whatever the mode, so a later mode change sees settled history.
  always_comb begin
    stb_sync_d    = stb_sync_q;
    ack_sync_d    = ack_sync_q;
    stb_sync_d[0] = stb_n;
    ack_sync_d[0] = ack_n;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stb_sync_d[i] = stb_sync_q[i-1];
      ack_sync_d[i] = ack_sync_q[i-1];
    end
    stb_hist_d = stb_sync_q[SYNC_STAGES-1];
    ack_hist_d = ack_sync_q[SYNC_STAGES-1];
  end

  assign stb_fall =  stb_hist_q & ~stb_sync_q[SYNC_STAGES-1];
  assign stb_rise = ~stb_hist_q &  stb_sync_q[SYNC_STAGES-1];
  assign ack_fall =  ack_hist_q & ~ack_sync_q[SYNC_STAGES-1];
  assign ack_rise = ~ack_hist_q &  ack_sync_q[SYNC_STAGES-1];

  // Priority: mode set > edge-driven set > rd/wr clear; on obf_n a CPU write beats an ack fall.
  always_comb begin
    ibf_d   = ibf_q;
    obf_n_d = obf_n_q;
    intr_d  = intr_q;
    if (clr || !mode) begin
      ibf_d   = 1'b0;
      obf_n_d = 1'b1;
      intr_d  = 1'b0;
    end else if (dir) begin
      obf_n_d = 1'b1;
      if (stb_fall)                    ibf_d  = 1'b1;
      else if (rd)                     ibf_d  = 1'b0;
      if (stb_rise && ibf_q && inte)   intr_d = 1'b1;
      else if (rd)                     intr_d = 1'b0;
    end else begin
      ibf_d = 1'b0;
      if (wr)                          obf_n_d = 1'b0;
      else if (ack_fall)               obf_n_d = 1'b1;
      if (ack_rise && inte)            intr_d  = 1'b1;
      else if (wr)                     intr_d  = 1'b0;
    end
  end

  // Idle-high reset on sync/history so releasing reset never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stb_sync_q <= '1;
      ack_sync_q <= '1;
      stb_hist_q <= 1'b1;
      ack_hist_q <= 1'b1;
      ibf_q      <= 1'b0;
      obf_n_q    <= 1'b1;
      intr_q     <= 1'b0;
    end else begin
      stb_sync_q <= stb_sync_d;
      ack_sync_q <= ack_sync_d;
      stb_hist_q <= stb_hist_d;
      ack_hist_q <= ack_hist_d;
      ibf_q      <= ibf_d;
      obf_n_q    <= obf_n_d;
      intr_q     <= intr_d;
    end
  end

  assign ibf   = ibf_q;
  assign obf_n = obf_n_q;
  assign intr  = intr_q;

endmodule

// File: rtl/ppi_hs_ctrl.sv
// Purpose: PPI control-word decode (mode set / bit set-reset), port C latch, two handshake channels.
// Latency: config and pc_out update at the edge after wr_ctrl; flags per ppi_hs_chan.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
// Ports: clk, reset (async high), bus (ppi_hs_ctrl_if.slave).
// Build option: PPI_INTE_EN -- when defined, inte_a/inte_b are flops loaded by bit set/reset
//               (A: PC4 when input, PC6 when output; B: PC2); otherwise both are tied high.
module ppi_hs_ctrl
  import ppi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  ppi_hs_ctrl_if.slave bus
);

  cfg_t       cfg_q, cfg_d;
  logic       cfg_err_q, cfg_err_d;
  logic [7:0] pc_out_q, pc_out_d;
  logic       mode_set;
  logic       inte_a, inte_b;
  amode_e     amode;

  assign mode_set = bus.wr_ctrl & bus.din[CW_SET];
  assign amode    = amode_e'(bus.din[CW_AMODE_HI:CW_AMODE_LO]);

`ifdef PPI_INTE_EN
  logic       inte_a_q, inte_a_d;
  logic       inte_b_q, inte_b_d;
  logic [2:0] inte_a_bit;
  // The enable for A lives on a different port C bit depending on its direction.
  assign inte_a_bit = cfg_q.dir_a ? INTE_A_IN_BIT : INTE_A_OUT_BIT;
  assign inte_a     = inte_a_q;
  assign inte_b     = inte_b_q;
`else
  assign inte_a = 1'b1;
  assign inte_b = 1'b1;
`endif

  always_comb begin
    cfg_d     = cfg_q;
    cfg_err_d = cfg_err_q;
    pc_out_d  = pc_out_q;
`ifdef PPI_INTE_EN
    inte_a_d  = inte_a_q;
    inte_b_d  = inte_b_q;
`endif
    if (bus.wr_ctrl) begin
      if (bus.din[CW_SET]) begin
        cfg_d.mode_a = (amode == AM_STROBED);
        cfg_d.dir_a  = bus.din[CW_DIR_A];
        cfg_d.dir_cu = bus.din[CW_DIR_CU];
        cfg_d.mode_b = bus.din[CW_MODE_B];
        cfg_d.dir_b  = bus.din[CW_DIR_B];
        cfg_d.dir_cl = bus.din[CW_DIR_CL];
        cfg_err_d    = !amode_is_legal(amode);
        pc_out_d     = 8'h00;
`ifdef PPI_INTE_EN
        inte_a_d     = 1'b0;
        inte_b_d     = 1'b0;
`endif
      end else begin
        pc_out_d[bus.din[BSR_SEL_HI:BSR_SEL_LO]] = bus.din[BSR_VAL];
`ifdef PPI_INTE_EN
        if (bus.din[BSR_SEL_HI:BSR_SEL_LO] == inte_a_bit) inte_a_d = bus.din[BSR_VAL];
        if (bus.din[BSR_SEL_HI:BSR_SEL_LO] == INTE_B_BIT) inte_b_d = bus.din[BSR_VAL];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q     <= CFG_RST;
      cfg_err_q <= 1'b0;
      pc_out_q  <= 8'h00;
`ifdef PPI_INTE_EN
      inte_a_q  <= 1'b0;
      inte_b_q  <= 1'b0;
`endif
    end else begin
      cfg_q     <= cfg_d;
      cfg_err_q <= cfg_err_d;
      pc_out_q  <= pc_out_d;
`ifdef PPI_INTE_EN
      inte_a_q  <= inte_a_d;
      inte_b_q  <= inte_b_d;
`endif
    end
  end

  ppi_hs_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan_a (
    .clk   (clk),
    .reset (reset),
    .mode  (cfg_q.mode_a),
    .dir   (cfg_q.dir_a),
    .inte  (inte_a),
    .clr   (mode_set),
    .rd    (bus.rd_a),
    .wr    (bus.wr_a),
    .stb_n (bus.stb_a_n),
    .ack_n (bus.ack_a_n),
    .ibf   (bus.ibf_a),
    .obf_n (bus.obf_a_n),
    .intr  (bus.intr_a)
  );

  ppi_hs_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan_b (
    .clk   (clk),
    .reset (reset),
    .mode  (cfg_q.mode_b),
    .dir   (cfg_q.dir_b),
    .inte  (inte_b),
    .clr   (mode_set),
    .rd    (bus.rd_b),
    .wr    (bus.wr_b),
    .stb_n (bus.stb_b_n),
    .ack_n (bus.ack_b_n),
    .ibf   (bus.ibf_b),
    .obf_n (bus.obf_b_n),
    .intr  (bus.intr_b)
  );

  assign bus.mode_a  = cfg_q.mode_a;
  assign bus.mode_b  = cfg_q.mode_b;
  assign bus.dir_a   = cfg_q.dir_a;
  assign bus.dir_cu  = cfg_q.dir_cu;
  assign bus.dir_b   = cfg_q.dir_b;
  assign bus.dir_cl  = cfg_q.dir_cl;
  assign bus.cfg_err = cfg_err_q;
  assign bus.pc_out  = pc_out_q;

endmodule

// File: tb/tb_ppi_hs_ctrl.sv
// Purpose: directed self-checking bench for ppi_hs_ctrl (control-word table + handshake sequences).
// Latency: n/a.
// Backpressure: n/a.
module tb_ppi_hs_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ppi_hs_ctrl_if bus ();

  ppi_hs_ctrl #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0] din;
    logic       ma, mb, da, dcu, db, dcl, err;
    logic [7:0] pc;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ctrl(input logic [7:0] d);
    bus.din     = d;
    bus.wr_ctrl = 1'b1;
    tick();
    bus.wr_ctrl = 1'b0;
  endtask

  function automatic logic [6:0] cfg_now();
    return {bus.mode_a, bus.mode_b, bus.dir_a, bus.dir_cu, bus.dir_b, bus.dir_cl, bus.cfg_err};
  endfunction

  function automatic logic [5:0] flags_now();
    return {bus.ibf_a, bus.ibf_b, bus.obf_a_n, bus.obf_b_n, bus.intr_a, bus.intr_b};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //             din    ma mb da dcu db dcl err  pc
    tbl[0]  = '{8'hB4, 1, 1, 1, 0, 0, 0, 0, 8'h00};
    tbl[1]  = '{8'hC0, 0, 0, 0, 0, 0, 0, 1, 8'h00};
    tbl[2]  = '{8'h80, 0, 0, 0, 0, 0, 0, 0, 8'h00};
    tbl[3]  = '{8'h0F, 0, 0, 0, 0, 0, 0, 0, 8'h80};
    tbl[4]  = '{8'h0A, 0, 0, 0, 0, 0, 0, 0, 8'h80};
    tbl[5]  = '{8'h0B, 0, 0, 0, 0, 0, 0, 0, 8'hA0};
    tbl[6]  = '{8'h01, 0, 0, 0, 0, 0, 0, 0, 8'hA1};
    tbl[7]  = '{8'h9B, 0, 0, 1, 1, 1, 1, 0, 8'h00};
    tbl[8]  = '{8'hE5, 0, 1, 0, 0, 0, 1, 1, 8'h00};
    tbl[9]  = '{8'h03, 0, 1, 0, 0, 0, 1, 1, 8'h02};
    tbl[10] = '{8'h0E, 0, 1, 0, 0, 0, 1, 1, 8'h02};
    tbl[11] = '{8'hA0, 1, 0, 0, 0, 0, 0, 0, 8'h00};

    reset       = 1'b1;
    bus.wr_ctrl = 1'b0;
    bus.din     = 8'h00;
    bus.rd_a    = 1'b0;
    bus.wr_a    = 1'b0;
    bus.rd_b    = 1'b0;
    bus.wr_b    = 1'b0;
    bus.stb_a_n = 1'b1;
    bus.ack_a_n = 1'b1;
    bus.stb_b_n = 1'b1;
    bus.ack_b_n = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick(2);

    // Reset state
    chk("rst_cfg",   32'(cfg_now()),   32'(7'b0011110));
    chk("rst_pc",    32'(bus.pc_out),  32'h00);
    chk("rst_flags", 32'(flags_now()), 32'(6'b001100));

    // Control-word table, state carried row to row
    for (int i = 0; i < 12; i++) begin
      ctrl(tbl[i].din);
      chk($sformatf("vec%0d_din%02h", i, tbl[i].din),
          32'({cfg_now(), bus.pc_out}),
          32'({tbl[i].ma, tbl[i].mb, tbl[i].da, tbl[i].dcu, tbl[i].db, tbl[i].dcl,
               tbl[i].err, tbl[i].pc}));
    end

    // Mode 0: handshake pins and strobes ignored
    ctrl(8'h9B);
    bus.stb_a_n = 1'b0;
    bus.wr_a    = 1'b1;
    tick();
    bus.wr_a    = 1'b0;
    tick(3);
    bus.stb_a_n = 1'b1;
    tick(4);
    chk("mode0_ignore", 32'({bus.ibf_a, bus.obf_a_n, bus.intr_a}), 32'(3'b010));

    // A strobed input: stb low 4 cycles, then rise, then read
    ctrl(8'hB4);
    ctrl(8'h09);
    bus.stb_a_n = 1'b0;
    tick(2);
    chk("ibf_a_before_3rd", 32'(bus.ibf_a), 32'd0);
    tick();
    chk("ibf_a_after_3rd",  32'(bus.ibf_a), 32'd1);
    tick();
    bus.stb_a_n = 1'b1;
    tick(2);
    chk("intr_a_early", 32'(bus.intr_a), 32'd0);
    tick();
    chk("intr_a_set",   32'({bus.ibf_a, bus.intr_a}), 32'(2'b11));
    bus.rd_a = 1'b1;
    tick();
    bus.rd_a = 1'b0;
    chk("rd_a_clear",   32'({bus.ibf_a, bus.intr_a}), 32'(2'b00));

    // B strobed output
    chk("obf_b_idle", 32'(bus.obf_b_n), 32'd1);
    bus.wr_b = 1'b1;
    tick();
    bus.wr_b = 1'b0;
    chk("obf_b_wr", 32'(bus.obf_b_n), 32'd0);
    bus.ack_b_n = 1'b0;
    tick(2);
    chk("obf_b_ack_early", 32'(bus.obf_b_n), 32'd0);
    tick();
    chk("obf_b_ack_fall",  32'(bus.obf_b_n), 32'd1);
    bus.ack_b_n = 1'b1;
    tick(2);
    chk("intr_b_early", 32'(bus.intr_b), 32'd0);
    tick();
    chk("intr_b_set",   32'(bus.intr_b), 32'd1);
    // wr_b lands in the same cycle the ack fall is detected
    bus.ack_b_n = 1'b0;
    tick(2);
    bus.wr_b = 1'b1;
    tick();
    bus.wr_b = 1'b0;
    chk("wr_beats_ack", 32'({bus.obf_b_n, bus.intr_b}), 32'(2'b00));
    tick(3);
    chk("obf_b_hold",   32'(bus.obf_b_n), 32'd0);
    bus.ack_b_n = 1'b1;
    tick(4);

    // Reset in the middle of an input handshake
    ctrl(8'hB4);
    bus.stb_a_n = 1'b0;
    tick(3);
    chk("pre_rst_ibf_a", 32'(bus.ibf_a), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_flags", 32'(flags_now()), 32'(6'b001100));
    chk("midrst_cfg",   32'({cfg_now(), bus.pc_out}), 32'({7'b0011110, 8'h00}));
    tick(2);
    reset = 1'b0;
    bus.stb_a_n = 1'b1;
    tick(6);
    chk("post_rst_flags", 32'(flags_now()), 32'(6'b001100));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
